// File: rtl/i2s_receiver.sv
// i2s_receiver: I2S capture of 24-bit left/right samples into a FIFO, drained to memory in fixed bursts.
//   clk, rst             system clock, synchronous active-high reset
//   enable               capture enable; low clears the word assembler and alignment
//   i2s_clock/lr/data    asynchronous I2S bit clock, word select (0 = left), serial data
//   write_request        burst request, held until write_ack
//   write_size           words per burst (constant BURST)
//   write_ack            one-cycle burst acceptance
//   write_data           {lr, 7'b0, sample[23:0]}, valid with write_strobe
//   write_strobe         one word per cycle for BURST cycles after write_ack
//   overrun              sticky: a finished word was dropped on a full FIFO
//   fifo_count           current FIFO occupancy
module i2s_receiver #(
   parameter int FIFO_AW = 4,
   parameter int BURST   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               i2s_clock,
   input  logic               i2s_lr,
   input  logic               i2s_data,
   output logic               write_request,
   output logic [23:0]        write_size,
   input  logic               write_ack,
   output logic [31:0]        write_data,
   output logic               write_strobe,
   output logic               overrun,
   output logic [FIFO_AW:0]   fifo_count
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = $clog2(BURST + 1);

   typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

   // clk_sr[2] is the previous value of the synchronized bit clock for edge detection
   logic [2:0]         clk_sr;
   logic [1:0]         lr_sr;
   logic [1:0]         dat_sr;
   logic               bit_evt;
   logic               lr_s;
   logic               dat_s;
   logic               lr_last;
   logic               lr_change;
   logic [23:0]        shift_reg;
   logic [23:0]        shift_nxt;
   logic [23:0]        sample;
   logic [4:0]         bit_count;
   logic [4:0]         count_nxt;
   logic               has_room;
   logic               aligned;
   logic               enable_d;
   logic               push;
   logic               pop;
   logic               full;
   logic               wr_ok;
   logic [31:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wp;
   logic [FIFO_AW-1:0] rp;
   state_t             state;
   state_t             state_nxt;
   logic [BW-1:0]      beat;

   assign bit_evt   = clk_sr[1] & ~clk_sr[2];
   assign lr_s      = lr_sr[1];
   assign dat_s     = dat_sr[1];
   assign lr_change = bit_evt & (lr_s != lr_last);

   // The bit that arrives with a new lr value still belongs to the old word
   assign has_room  = bit_count < 5'd24;
   assign shift_nxt = has_room ? {shift_reg[22:0], dat_s} : shift_reg;
   assign count_nxt = has_room ? bit_count + 5'd1 : bit_count;
   assign sample    = shift_nxt << (5'd24 - count_nxt);

   // Only words that started after alignment are kept; a pop frees a slot in the same cycle
   assign push  = lr_change & enable & aligned;
   assign full  = fifo_count == (FIFO_AW+1)'(DEPTH);
   assign wr_ok = push & (~full | pop);

   assign write_request = state == REQ;
   assign write_size    = 24'(BURST);

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sr <= '0;
         lr_sr  <= '0;
         dat_sr <= '0;
      end else begin
         clk_sr <= {clk_sr[1:0], i2s_clock};
         lr_sr  <= {lr_sr[0], i2s_lr};
         dat_sr <= {dat_sr[0], i2s_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         bit_count <= '0;
         aligned   <= 1'b0;
         lr_last   <= 1'b0;
         enable_d  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         enable_d <= enable;
         if (bit_evt) lr_last <= lr_s;
         if (!enable) begin
            shift_reg <= '0;
            bit_count <= '0;
            aligned   <= 1'b0;
         end else if (lr_change) begin
            shift_reg <= '0;
            bit_count <= '0;
            aligned   <= 1'b1;
         end else if (bit_evt) begin
            shift_reg <= shift_nxt;
            bit_count <= count_nxt;
         end
         if (enable & ~enable_d) overrun <= 1'b0;
         else if (push & full & ~pop) overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wp] <= {lr_last, 7'd0, sample};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         fifo_count <= '0;
      end else begin
         wp         <= wp + FIFO_AW'(wr_ok);
         rp         <= rp + FIFO_AW'(pop);
         fifo_count <= fifo_count + (FIFO_AW+1)'(wr_ok) - (FIFO_AW+1)'(pop);
      end
   end

   // The first word pops on the ack cycle so the first strobe follows write_ack directly;
   // beat counts the pops still owed in XFER
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: if (fifo_count >= (FIFO_AW+1)'(BURST)) state_nxt = REQ;
         REQ: if (write_ack) begin
            state_nxt = XFER;
            pop       = 1'b1;
         end
         XFER: if (beat == '0) state_nxt = IDLE; else pop = 1'b1;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         beat         <= '0;
         write_strobe <= 1'b0;
         write_data   <= '0;
      end else begin
         state        <= state_nxt;
         write_strobe <= pop;
         if (pop) write_data <= mem[rp];
         if (state == REQ) beat <= BW'(BURST - 1);
         else if (pop) beat <= beat - 1'b1;
      end
   end
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: directed I2S slots against a slot-level model of expected FIFO words.
module tb_i2s_receiver;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        i2s_clock;
   logic        i2s_lr;
   logic        i2s_data;
   logic        write_request;
   logic [23:0] write_size;
   logic        write_ack;
   logic [31:0] write_data;
   logic        write_strobe;
   logic        overrun;
   logic [4:0]  fifo_count;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got[$];
   int          rd = 0;
   int          ack_req = 0;
   int          ack_seen = 0;
   bit          aligned_m = 1'b0;
   bit          ovf_m = 1'b0;
   logic        cur_lr = 1'b0;

   i2s_receiver #(.FIFO_AW(4), .BURST(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .i2s_clock(i2s_clock), .i2s_lr(i2s_lr),
      .i2s_data(i2s_data), .write_request(write_request), .write_size(write_size),
      .write_ack(write_ack), .write_data(write_data), .write_strobe(write_strobe),
      .overrun(overrun), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Memory side: one ack pulse per request token, only while a request is pending
   initial begin
      write_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (write_ack) write_ack = 1'b0;
         else if (ack_seen != ack_req && write_request) begin
            write_ack = 1'b1;
            ack_seen++;
         end
      end
   end

   // Every strobed word must be the next word the model expects
   initial begin
      forever begin
         @(negedge clk);
         if (rst) rd = exp_q.size();
         else if (write_strobe) begin
            got.push_back(write_data);
            if (rd >= exp_q.size()) begin
               n_tests++;
               n_fail++;
               $display("FAIL strobe_word: got %h expected no strobe (model empty)", write_data);
            end else begin
               check("strobe_word", write_data, exp_q[rd]);
               rd++;
            end
         end
      end
   end

   task automatic set_en(input logic v);
      if (v && !enable) ovf_m = 1'b0;
      if (!v) aligned_m = 1'b0;
      enable = v;
   endtask

   task automatic send_bit(input logic lr, input logic d, input bit ackf);
      @(negedge clk);
      i2s_lr = lr;
      i2s_data = d;
      i2s_clock = 1'b0;
      cur_lr = lr;
      repeat (4) @(negedge clk);
      i2s_clock = 1'b1;
      if (ackf) ack_req++;
      repeat (4) @(negedge clk);
   endtask

   // One slot on the current channel; its last bit carries the flipped lr
   task automatic send_slot(input logic [23:0] value, input int width, input int slen,
                            input int en_at, input bit ackf);
      logic this_lr;
      logic d;
      logic [23:0] lj;
      this_lr = cur_lr;
      for (int i = 0; i < slen; i++) begin
         if (i == en_at) set_en(1'b1);
         d = 1'b0;
         if (i < width) d = value[width-1-i];
         send_bit(i == slen - 1 ? ~this_lr : this_lr, d, ackf && i == slen - 1);
      end
      if (enable) begin
         if (aligned_m) begin
            lj = value << (24 - width);
            if (exp_q.size() - rd >= 16) ovf_m = 1'b1;
            else exp_q.push_back({this_lr, 7'd0, lj});
         end
         aligned_m = 1'b1;
      end
   endtask

   task automatic drain();
      ack_req++;
      repeat (16) @(negedge clk);
   endtask

   task automatic check_model_count(input string name);
      check(name, 32'(fifo_count), 32'(exp_q.size() - rd));
   endtask

   initial begin
      int n;
      rst = 1'b1;
      enable = 1'b0;
      i2s_clock = 1'b0;
      i2s_lr = 1'b0;
      i2s_data = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_request", 32'(write_request), 0);
      check("rst_strobe", 32'(write_strobe), 0);
      check("rst_data", write_data, 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_size", 32'(write_size), 8);
      rst = 1'b0;

      send_bit(1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0, 1'b0);
      set_en(1'b1);
      send_slot(24'h777777, 24, 32, -1, 1'b0);
      check("align_discard", 32'(fifo_count), 0);
      repeat (4) begin
         send_slot(24'hABCDEF, 24, 32, -1, 1'b0);
         send_slot(24'h123456, 24, 32, -1, 1'b0);
      end
      repeat (2) @(negedge clk);
      check("stereo_count", 32'(fifo_count), 8);
      check("stereo_request", 32'(write_request), 1);
      drain();
      check("stereo_words", got.size(), 8);
      check("stereo_first", got[0], 32'h00ABCDEF);
      check("stereo_second", got[1], 32'h80123456);
      check("stereo_drained", 32'(fifo_count), 0);

      repeat (4) begin
         send_slot(24'h00BEEF, 16, 16, -1, 1'b0);
         send_slot(24'h00CAFE, 16, 16, -1, 1'b0);
      end
      repeat (2) @(negedge clk);
      check_model_count("w16_count");
      drain();
      check("w16_left", got[8], 32'h00BEEF00);
      check("w16_right", got[9], 32'h80CAFE00);

      set_en(1'b0);
      repeat (2) @(negedge clk);
      send_slot(24'h111111, 24, 32, 10, 1'b0);
      check("midword_discard", 32'(fifo_count), 0);
      send_slot(24'h222222, 24, 32, -1, 1'b0);
      repeat (2) @(negedge clk);
      check("first_word", 32'(fifo_count), 1);

      for (int k = 0; k < 16; k++) send_slot(24'h0A0000 + 24'(k), 24, 32, -1, 1'b0);
      repeat (2) @(negedge clk);
      check("ovr_count", 32'(fifo_count), 16);
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_model", 32'(overrun), 32'(ovf_m));
      check("ovr_request", 32'(write_request), 1);
      drain();
      drain();
      check("ovr_drained", 32'(fifo_count), 0);
      check("ovr_sticky", 32'(overrun), 1);
      set_en(1'b0);
      repeat (2) @(negedge clk);
      set_en(1'b1);
      repeat (2) @(negedge clk);
      check("ovr_cleared", 32'(overrun), 0);

      send_slot(24'h333333, 24, 32, -1, 1'b0);
      for (int k = 0; k < 8; k++) send_slot(24'h5A0000 + 24'(k), 24, 32, -1, 1'b0);
      send_slot(24'h5AFFFF, 24, 32, -1, 1'b1);
      repeat (12) @(negedge clk);
      check("collide_count", 32'(fifo_count), 1);
      check_model_count("collide_model");

      for (int k = 0; k < 7; k++) send_slot(24'h6B0000 + 24'(k), 24, 32, -1, 1'b0);
      repeat (2) @(negedge clk);
      check("prerst_count", 32'(fifo_count), 8);
      ack_req++;
      n = 0;
      for (int t = 0; t < 50 && n < 3; t++) begin
         @(negedge clk);
         if (write_strobe) n++;
      end
      check("three_strobes", n, 3);
      #1;
      rst = 1'b1;
      i2s_clock = 1'b0;
      aligned_m = 1'b0;
      ovf_m = 1'b0;
      @(negedge clk);
      check("midrst_strobe", 32'(write_strobe), 0);
      check("midrst_request", 32'(write_request), 0);
      check("midrst_data", write_data, 0);
      check("midrst_count", 32'(fifo_count), 0);
      check("midrst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("postrst_count", 32'(fifo_count), 0);
      check("postrst_request", 32'(write_request), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

Receive-side counterpart of the audio output path. Samples an externally driven I2S bit clock, word select and serial data; deserializes 24-bit left/right samples MSB-first; buffers them in an internal FIFO; bursts them to memory through a request/acknowledge/strobe interface that mirrors the playback path's read interface. It sits between the codec ADC pins and the wishbone memory master.

## Interface
- FIFO_AW, 4, log2 of FIFO depth (16 words).
- BURST, 8, words per memory burst; must be ≤ 2^FIFO_AW.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture enable.
- i2s_clock  input  1  external bit clock (asynchronous to clk).
- i2s_lr  input  1  word select; 0 = left, 1 = right.
- i2s_data  input  1  serial data.
- write_request  output  1  burst request to memory.
- write_size  output  24  words in the burst; constant BURST.
- write_ack  input  1  one-cycle pulse; memory accepts the burst.
- write_data  output  32  sample word.
- write_strobe  output  1  write_data valid this cycle.
- overrun  output  1  sticky: a sample was dropped because the FIFO was full.
- fifo_count  output  FIFO_AW+1  current FIFO occupancy.

## Operation
- i2s_clock, i2s_lr, i2s_data each pass through a 2-flop synchronizer. A bit event is a rising edge of synchronized i2s_clock (sync = 1, previous = 0).
- On each bit event, compare the sampled lr with the lr latched at the previous bit event:
  - **No change:** if bit_count < 24, shift data into the LSB of a 24-bit shift register and increment bit_count. Bits beyond 24 are ignored.
  - **Change:** the bit belongs to the old word. Shift it in (if bit_count < 24), then finalize the word with the old channel, clear the shift register, and set bit_count = 0.
- Finalize:
  - sample = shift_reg << (24 − bit_count). Short words are left-justified and zero-padded.
  - FIFO word = {old_lr, 7'b0, sample[23:0]}.
  - Push only if the aligned flag is set.
  - If the FIFO is full, drop the word and set overrun.
- Alignment:
  - The aligned flag clears on rst or when enable = 0.
  - It sets at the first lr change seen while enable = 1. The partial word ending at that change is discarded.
- enable = 0 clears the shift register, bit_count and the aligned flag. The FIFO contents and any burst in progress are unaffected.
- overrun clears on rst or on a rising edge of enable.
- Writer FSM:
  - **IDLE:** when fifo_count ≥ BURST, go to REQ.
  - **REQ:** write_request = 1 until write_ack. On write_ack, go to BURST.
  - **BURST:** pop one word per cycle with write_strobe = 1 for exactly BURST consecutive cycles, then go to IDLE.
  - Memory must sink one word per cycle during BURST. The FIFO cannot underflow there because the count was ≥ BURST at entry.
- Simultaneous FIFO push and pop in the same cycle are both honoured; fifo_count stays unchanged. A push while full that coincides with a pop succeeds.
- The FIFO is a circular buffer; read and write pointers wrap modulo 2^FIFO_AW.

## Timing
- Reset values: write_request = 0, write_strobe = 0, write_data = 0, overrun = 0, fifo_count = 0, write_size = BURST. FSM returns to IDLE; the FIFO is emptied; synchronizers are cleared.
- Requirement: i2s_clock high and low phases each ≥ 3 clk periods.
- Bit event occurs 3 clk cycles after the raw i2s_clock rising edge (2 synchronizer stages + edge detect).
- A finalized word is visible in fifo_count on the cycle after the bit event.
- write_request rises the cycle after fifo_count ≥ BURST is seen in IDLE.
- The first write_strobe occurs the cycle after write_ack. write_data is registered and aligned with write_strobe.
- A write_ack while not in REQ is ignored.
- rst asserted mid-burst: write_strobe and write_request drop on the next cycle; the remaining words are lost.

## Test plan
- **Stereo capture, BURST = 8:** 32-bit slots, left = 0xABCDEF, right = 0x123456, 4 frames after alignment → one request; after write_ack, 8 strobes alternating 0x00ABCDEF / 0x80123456, starting with the first complete word after the aligning lr edge.
- **16-bit slots:** left = 0xBEEF → word 0x00BEEF00 (left-justified, zero-padded).
- **Alignment:** assert enable mid-word → the partial word is never written; fifo_count stays 0 until the first complete word.
- **Overrun:** hold write_ack low, capture 17 words with FIFO_AW = 4 → fifo_count = 16, overrun = 1; ack → the 16 oldest words are delivered in order. Toggle enable → overrun = 0.
- **Push/pop collision:** a word completes during BURST → fifo_count reflects the net change, with no lost or duplicated word (checked against a scoreboard).
- **Reset mid-burst:** assert rst after the 3rd strobe → no further strobes; all outputs at reset values the next cycle; fifo_count = 0.
